bulls_cows_engine: RTL and testbench
====================================

Name: bulls_cows_engine

Overview:
- Parametrised scoring core for the number-guessing game ("xAyB" scoring).
- The first accepted keypad entry is latched as the secret answer.
- Each later entry is scored digit-serially against the answer, producing A (right digit, right position) and B (digit present, wrong position).
- Tracks attempt count and win/lose status, and feeds the VGA text overlay (play banner, a/b hint glyphs, result text).

Parameters:
- DIGITS, 3: number of digits per answer/guess (2..8).
- DW, 4: bits per digit.
- CW, 2: width of A/B counts; must satisfy 2^CW > DIGITS.
- MAX_TRY, 10: guesses allowed before the game is lost (1..2^TW-1).
- TW, 4: width of attempt counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- iNum  input  DIGITS*DW  entry; digit k at bits [k*DW +: DW], digit 0 in the LSBs.
- iNumRdy  input  1  one-cycle strobe, iNum valid.
- iClear  input  1  synchronous restart to IDLE.
- oPlay  output  1  answer latched, game in progress (PLAY or SCORE).
- oBusy  output  1  scoring in progress; iNumRdy ignored.
- oValid  output  1  one-cycle pulse, oA/oB updated.
- oA  output  CW  exact-position matches of last guess.
- oB  output  CW  wrong-position matches of last guess.
- oTries  output  TW  guesses scored this game.
- oWin  output  1  level, last guess had A==DIGITS.
- oLose  output  1  level, MAX_TRY guesses scored without win.

Behaviour:
- Reset (async, reset=0): state IDLE; answer, guess, oA, oB, oTries all 0; oPlay, oBusy, oValid, oWin, oLose all 0.
- States: IDLE, PLAY, SCORE, WIN, LOSE.
- IDLE: on iNumRdy, latch iNum as answer and go to PLAY. No oValid pulse; oTries unchanged.
- PLAY, iNumRdy at cycle t:
  - latch iNum as guess, clear the internal accumulators, set index i=0, go to SCORE.
  - oBusy=1 from t+1.
- SCORE: one guess digit per cycle, for cycles t+1..t+DIGITS.
  - If g[i]==ans[i], A+1.
  - Else if g[i]==ans[j] for any j!=i, B+1. All j are compared in parallel.
  - Each guess digit counts at most once. Duplicate digits in the guess or answer follow this rule only; no de-duplication.
  - After i==DIGITS-1, in cycle t+DIGITS+1: oA/oB load, oValid=1 for one cycle, oTries+1 (saturating), oBusy=0.
  - Next state is decided in that same cycle: WIN if A==DIGITS; else LOSE if the new oTries==MAX_TRY; else PLAY.
  - Latency from iNumRdy to oValid is DIGITS+1 cycles.
- iNumRdy during SCORE, WIN or LOSE: ignored, with no queueing.
- WIN/LOSE: oWin or oLose holds at 1. oA/oB/oTries hold. oPlay=0.
- iClear: highest synchronous priority in every state, including mid-SCORE.
  - Next cycle: IDLE with all outputs at reset values.
  - An iNumRdy in the same cycle is dropped.
- Win takes precedence over lose on the final allowed guess.
- Digit values are compared as raw DW-bit codes; values above 9 are legal.
- Async reset mid-SCORE aborts immediately. No partial oValid is produced.

Test Plan (DIGITS=3, DW=4, MAX_TRY=3 unless noted):
- Reset, then iNumRdy with iNum=12'h321 -> IDLE to PLAY, oPlay=1, no oValid, oTries=0.
- Guess 12'h231 -> oBusy high 3 cycles, oValid on the 4th cycle after the strobe, oA=1, oB=2, oTries=1.
- Guess 12'h111 -> oA=1, oB=2 (duplicate rule). Then guess 12'h321 -> oA=3, oB=0, oWin=1, further iNumRdy ignored.
- After iClear and answer 12'h321: guesses 12'h456, 12'h654, 12'h987 -> each 0A0B; after the third, oLose=1, oTries=3, oPlay=0.
- Strobe iNumRdy on the cycle after a guess strobe (during SCORE) -> ignored, single oValid, result matches the first guess only.
- iClear (and separately reset=0) asserted in the 2nd SCORE cycle -> no oValid, IDLE, all outputs 0; next iNumRdy latches a new answer.

Source files
------------

// File: rtl/bulls_cows_engine_if.sv
// Handshake and status bundle between the keypad/VGA side and the bulls-and-cows scoring core.
// The master drives entries and clear; the slave (the engine) returns score and game status.
interface bulls_cows_engine_if #(
    parameter int DIGITS = 3,
    parameter int DW     = 4,
    parameter int CW     = 2,
    parameter int TW     = 4
);
    logic [DIGITS*DW-1:0] iNum;
    logic                 iNumRdy;
    logic                 iClear;
    logic                 oPlay;
    logic                 oBusy;
    logic                 oValid;
    logic [CW-1:0]        oA;
    logic [CW-1:0]        oB;
    logic [TW-1:0]        oTries;
    logic                 oWin;
    logic                 oLose;

    modport master (
        output iNum, iNumRdy, iClear,
        input  oPlay, oBusy, oValid, oA, oB, oTries, oWin, oLose
    );

    modport slave (
        input  iNum, iNumRdy, iClear,
        output oPlay, oBusy, oValid, oA, oB, oTries, oWin, oLose
    );
endinterface

// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows (xAyB) scoring core: latches a secret answer, then scores each guess one digit
// per cycle against all answer digits in parallel, tracking attempts and the win/lose outcome.
module bulls_cows_engine #(
    parameter int DIGITS  = 3,
    parameter int DW      = 4,
    parameter int CW      = 2,
    parameter int MAX_TRY = 10,
    parameter int TW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    bulls_cows_engine_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {IDLE, PLAY, SCORE, WIN, LOSE} state_t;

    state_t               state;
    state_t               next_state;
    logic [DIGITS*DW-1:0] answer;
    logic [DIGITS*DW-1:0] guess;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        acc_a;
    logic [CW-1:0]        acc_b;
    logic [CW-1:0]        a_q;
    logic [CW-1:0]        b_q;
    logic [TW-1:0]        tries;
    logic                 valid_q;

    logic [DW-1:0]        cur;
    logic                 exact;
    logic                 present;
    logic                 last;
    logic [CW-1:0]        new_a;
    logic [CW-1:0]        new_b;
    logic [TW-1:0]        tries_inc;

    // A digit that misses its own position scores B if it appears anywhere else in the answer.
    always_comb begin
        cur     = guess[idx*DW +: DW];
        exact   = (cur == answer[idx*DW +: DW]);
        present = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j != int'(idx) && cur == answer[j*DW +: DW]) begin
                present = 1'b1;
            end
        end
        last      = (idx == IW'(DIGITS - 1));
        new_a     = acc_a + CW'(exact);
        new_b     = acc_b + CW'(!exact && present);
        tries_inc = (tries == {TW{1'b1}}) ? tries : tries + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.iClear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.iNumRdy) next_state = PLAY;
                PLAY:    if (bus.iNumRdy) next_state = SCORE;
                SCORE: begin
                    // Win is checked first so a perfect final guess never reports a loss.
                    if (last) begin
                        if (new_a == CW'(DIGITS))            next_state = WIN;
                        else if (tries_inc == TW'(MAX_TRY))  next_state = LOSE;
                        else                                 next_state = PLAY;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            answer  <= '0;
            guess   <= '0;
            idx     <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tries   <= '0;
            valid_q <= 1'b0;
        end else if (bus.iClear) begin
            answer  <= '0;
            guess   <= '0;
            idx     <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tries   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iNumRdy) answer <= bus.iNum;
                end
                PLAY: begin
                    if (bus.iNumRdy) begin
                        guess <= bus.iNum;
                        acc_a <= '0;
                        acc_b <= '0;
                        idx   <= '0;
                    end
                end
                SCORE: begin
                    if (last) begin
                        a_q     <= new_a;
                        b_q     <= new_b;
                        tries   <= tries_inc;
                        valid_q <= 1'b1;
                    end else begin
                        acc_a <= new_a;
                        acc_b <= new_b;
                        idx   <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oPlay  = (state == PLAY) || (state == SCORE);
    assign bus.oBusy  = (state == SCORE);
    assign bus.oValid = valid_q;
    assign bus.oA     = a_q;
    assign bus.oB     = b_q;
    assign bus.oTries = tries;
    assign bus.oWin   = (state == WIN);
    assign bus.oLose  = (state == LOSE);
endmodule

// File: tb/tb_bulls_cows_engine.sv
// Self-checking bench for bulls_cows_engine: directed game sequences, a table of scoring vectors,
// and randomized games scored by a digit-counting reference model.
module tb_bulls_cows_engine;
    localparam int DIGITS  = 3;
    localparam int DW      = 4;
    localparam int CW      = 2;
    localparam int MAX_TRY = 3;
    localparam int TW      = 4;
    localparam int NW      = DIGITS * DW;

    typedef struct {
        logic [NW-1:0] ans;
        logic [NW-1:0] guess;
        int            a;
        int            b;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bulls_cows_engine_if #(.DIGITS(DIGITS), .DW(DW), .CW(CW), .TW(TW)) bus ();

    bulls_cows_engine #(
        .DIGITS(DIGITS), .DW(DW), .CW(CW), .MAX_TRY(MAX_TRY), .TW(TW)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int            checks = 0;
    int            errors = 0;
    logic [NW-1:0] m_answer;
    int            m_tries;
    bit            m_play, m_win, m_lose;
    vec_t          vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scores straight from the game rules: exact position first, otherwise any other position.
    function automatic void model_score(input logic [NW-1:0] ans, input logic [NW-1:0] g,
                                        output int a, output int b);
        logic [DW-1:0] ad[DIGITS];
        logic [DW-1:0] gd[DIGITS];
        bit            found;
        a = 0;
        b = 0;
        for (int i = 0; i < DIGITS; i++) begin
            ad[i] = ans[i*DW +: DW];
            gd[i] = g[i*DW +: DW];
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (gd[i] == ad[i]) a++;
            else begin
                found = 0;
                for (int j = 0; j < DIGITS; j++) if (j != i && gd[i] == ad[j]) found = 1;
                if (found) b++;
            end
        end
    endfunction

    function automatic logic [NW-1:0] rand_num();
        logic [NW-1:0] n;
        for (int i = 0; i < DIGITS; i++) begin
            n[i*DW +: DW] = ($urandom % 3 == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 3));
        end
        return n;
    endfunction

    task automatic model_clear();
        m_tries = 0;
        m_play  = 0;
        m_win   = 0;
        m_lose  = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_play"},  bus.oPlay,  0);
        check({tag, "_busy"},  bus.oBusy,  0);
        check({tag, "_valid"}, bus.oValid, 0);
        check({tag, "_a"},     bus.oA,     0);
        check({tag, "_b"},     bus.oB,     0);
        check({tag, "_tries"}, bus.oTries, 0);
        check({tag, "_win"},   bus.oWin,   0);
        check({tag, "_lose"},  bus.oLose,  0);
    endtask

    task automatic check_output(input string tag);
        check({tag, "_tries"}, bus.oTries, m_tries);
        check({tag, "_win"},   bus.oWin,   m_win);
        check({tag, "_lose"},  bus.oLose,  m_lose);
        check({tag, "_play"},  bus.oPlay,  m_play);
    endtask

    task automatic apply_stimulus(input logic [NW-1:0] n);
        @(negedge clk);
        bus.iNum    = n;
        bus.iNumRdy = 1'b1;
        @(negedge clk);
        bus.iNumRdy = 1'b0;
    endtask

    task automatic clear_game();
        @(negedge clk);
        bus.iClear = 1'b1;
        @(negedge clk);
        bus.iClear = 1'b0;
        model_clear();
        check_idle("clear");
    endtask

    task automatic start_game(input logic [NW-1:0] ans);
        apply_stimulus(ans);
        m_answer = ans;
        m_play   = 1;
        check("start_play",  bus.oPlay,  1);
        check("start_valid", bus.oValid, 0);
        check("start_tries", bus.oTries, 0);
        check("start_busy",  bus.oBusy,  0);
    endtask

    task automatic score_guess(input string tag, input logic [NW-1:0] g, input int ea, input int eb);
        apply_stimulus(g);
        for (int k = 0; k < DIGITS; k++) begin
            check({tag, "_busy"},    bus.oBusy,  1);
            check({tag, "_novalid"}, bus.oValid, 0);
            @(negedge clk);
        end
        m_tries = (m_tries == 15) ? 15 : m_tries + 1;
        if (ea == DIGITS)            m_win  = 1;
        else if (m_tries == MAX_TRY) m_lose = 1;
        m_play = !(m_win || m_lose);
        check({tag, "_valid"},   bus.oValid, 1);
        check({tag, "_busydone"}, bus.oBusy, 0);
        check({tag, "_a"},       bus.oA,     ea);
        check({tag, "_b"},       bus.oB,     eb);
        check_output(tag);
        @(negedge clk);
        check({tag, "_pulse"}, bus.oValid, 0);
    endtask

    task automatic ignored_strobe(input string tag, input logic [NW-1:0] g);
        apply_stimulus(g);
        for (int k = 0; k < DIGITS + 2; k++) begin
            check({tag, "_valid"}, bus.oValid, 0);
            check({tag, "_busy"},  bus.oBusy,  0);
            @(negedge clk);
        end
        check_output(tag);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            ra, rb;
        logic [NW-1:0] g;

        vecs[0] = '{12'h321, 12'h231, 1, 2};
        vecs[1] = '{12'h321, 12'h111, 1, 2};
        vecs[2] = '{12'h112, 12'h121, 1, 2};
        vecs[3] = '{12'hFAB, 12'hBAF, 1, 2};
        vecs[4] = '{12'h000, 12'h000, 3, 0};
        vecs[5] = '{12'h123, 12'h312, 0, 3};
        vecs[6] = '{12'h321, 12'h456, 0, 0};
        vecs[7] = '{12'h555, 12'h5A5, 2, 0};
        vecs[8] = '{12'h9EF, 12'hF9E, 0, 3};
        vecs[9] = '{12'h5A5, 12'h555, 2, 1};

        bus.iNum    = '0;
        bus.iNumRdy = 1'b0;
        bus.iClear  = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        model_clear();

        // Directed game ending in a win on the last allowed guess.
        start_game(12'h321);
        score_guess("g231", 12'h231, 1, 2);
        score_guess("g111", 12'h111, 1, 2);
        score_guess("g321", 12'h321, 3, 0);
        ignored_strobe("win_ignore", 12'h456);

        clear_game();
        start_game(12'h321);
        score_guess("lose1", 12'h456, 0, 0);
        score_guess("lose2", 12'h654, 0, 0);
        score_guess("lose3", 12'h987, 0, 0);
        ignored_strobe("lose_ignore", 12'h321);

        foreach (vecs[v]) begin
            clear_game();
            start_game(vecs[v].ans);
            score_guess($sformatf("vec%0d", v), vecs[v].guess, vecs[v].a, vecs[v].b);
        end

        // Second strobe during SCORE must not queue a second result.
        clear_game();
        start_game(12'h321);
        @(negedge clk);
        bus.iNum    = 12'h231;
        bus.iNumRdy = 1'b1;
        @(negedge clk);
        bus.iNum    = 12'h321;
        check("dup_busy1", bus.oBusy, 1);
        @(negedge clk);
        bus.iNumRdy = 1'b0;
        check("dup_busy2", bus.oBusy, 1);
        @(negedge clk);
        check("dup_busy3", bus.oBusy, 1);
        @(negedge clk);
        check("dup_valid", bus.oValid, 1);
        check("dup_a", bus.oA, 1);
        check("dup_b", bus.oB, 2);
        m_tries = 1;
        check_output("dup");
        for (int k = 0; k < DIGITS + 2; k++) begin
            @(negedge clk);
            check("dup_single", bus.oValid, 0);
        end

        // iClear in the second SCORE cycle, with a simultaneous strobe that must be dropped.
        apply_stimulus(12'h123);
        @(negedge clk);
        bus.iClear  = 1'b1;
        bus.iNumRdy = 1'b1;
        bus.iNum    = 12'h777;
        @(negedge clk);
        bus.iClear  = 1'b0;
        bus.iNumRdy = 1'b0;
        model_clear();
        check_idle("midclr");
        for (int k = 0; k < DIGITS + 2; k++) begin
            @(negedge clk);
            check("midclr_valid", bus.oValid, 0);
            check("midclr_play",  bus.oPlay,  0);
        end
        start_game(12'h456);
        score_guess("midclr_new", 12'h456, 3, 0);

        // Async reset in the second SCORE cycle.
        clear_game();
        start_game(12'h321);
        apply_stimulus(12'h231);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < DIGITS + 2; k++) begin
            @(negedge clk);
            check("midrst_valid", bus.oValid, 0);
        end
        start_game(12'h654);
        score_guess("midrst_new", 12'h645, 1, 2);

        // Randomized games against the reference model.
        for (int game = 0; game < 40; game++) begin
            clear_game();
            start_game(rand_num());
            while (m_play) begin
                g = ($urandom % 4 == 0) ? m_answer : rand_num();
                model_score(m_answer, g, ra, rb);
                score_guess($sformatf("rand%0d", game), g, ra, rb);
            end
            ignored_strobe($sformatf("rand%0d_end", game), rand_num());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
